// File: rtl/branch_update_unit_if.sv
// Resolved-branch input bus and BTB write-port bus for branch_update_unit.
// The producer/BTB side uses master; the unit itself uses slave.
interface branch_update_unit_if;
   logic        res_valid;
   logic        res_ready;
   logic [31:0] res_pc;
   logic        res_taken;
   logic [31:0] res_target;
   logic [1:0]  res_pred_state;
   logic [31:0] res_pred_target;
   logic        flush;
   logic [31:0] flush_pc;
   logic        btb_wen;
   logic [31:0] btb_wsel;
   logic [1:0]  btb_wstate;
   logic [31:0] btb_wtarget;
   logic        btb_phit;
   logic        btb_stall;

   modport master (
      output res_valid, res_pc, res_taken, res_target, res_pred_state, res_pred_target, btb_stall,
      input  res_ready, flush, flush_pc, btb_wen, btb_wsel, btb_wstate, btb_wtarget, btb_phit
   );

   modport slave (
      input  res_valid, res_pc, res_taken, res_target, res_pred_state, res_pred_target, btb_stall,
      output res_ready, flush, flush_pc, btb_wen, btb_wsel, btb_wstate, btb_wtarget, btb_phit
   );
endinterface

// File: rtl/branch_update_unit.sv
// Mispredict detection, registered flush and BTB update FIFO at EX/MEM.
// Optional BRANCH_UPDATE_STATS_EN adds saturating branch/mispredict counters.
module branch_update_unit #(
   parameter int DEPTH = 4,
   parameter int IDX_W = 8
) (
   input logic CLK,
   input logic RST,
   branch_update_unit_if.slave bu
`ifdef BRANCH_UPDATE_STATS_EN
   ,
   output logic [31:0] stat_branches,
   output logic [31:0] stat_mispred,
   input  logic        stat_clr
`endif
);
   localparam logic [1:0] BPRED_NS = 2'd0;
   localparam logic [1:0] BPRED_NH = 2'd1;
   localparam logic [1:0] BPRED_TS = 2'd2;
   localparam logic [1:0] BPRED_TH = 2'd3;
   localparam int AW = $clog2(DEPTH);

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || IDX_W < 1 || IDX_W > 30) begin : g_bad_param
      $error("branch_update_unit: DEPTH must be a power of 2 >= 2, IDX_W in 1..30");
   end

   typedef struct packed {
      logic [31:0] pc;
      logic [1:0]  state;
      logic [31:0] target;
      logic        phit;
   } upd_t;

   upd_t          mem [DEPTH];
   upd_t          entry;
   upd_t          head;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          pred_taken;
   logic          dir_miss;
   logic          tgt_miss;
   logic          mispredict;
   logic          push;
   logic          pop;
   logic          empty;
   logic [31:0]   fix_pc;

   always_comb begin
      pred_taken   = (bu.res_pred_state == BPRED_TS) || (bu.res_pred_state == BPRED_TH);
      dir_miss     = pred_taken != bu.res_taken;
      tgt_miss     = bu.res_taken && pred_taken && (bu.res_pred_target != bu.res_target);
      mispredict   = dir_miss || tgt_miss;
      fix_pc       = bu.res_taken ? bu.res_target : bu.res_pc + 32'd4;
      empty        = (count == '0);
      push         = bu.res_valid && bu.res_ready;
      pop          = !empty && !bu.btb_stall;
      entry.pc     = bu.res_pc;
      entry.state  = bu.res_pred_state;
      // A not-taken outcome rewrites the target the BTB already holds.
      entry.target = bu.res_taken ? bu.res_target : bu.res_pred_target;
      entry.phit   = !dir_miss;
      head         = empty ? '0 : mem[rd_ptr];
   end

   assign bu.res_ready   = count < (AW+1)'(DEPTH);
   assign bu.btb_wen     = !empty;
   assign bu.btb_wsel    = head.pc;
   assign bu.btb_wstate  = head.state;
   assign bu.btb_wtarget = head.target;
   assign bu.btb_phit    = head.phit;

   always_ff @(posedge CLK) begin
      if (push) mem[wr_ptr] <= entry;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         bu.flush    <= 1'b0;
         bu.flush_pc <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
         bu.flush    <= push && mispredict;
         bu.flush_pc <= (push && mispredict) ? fix_pc : '0;
      end
   end

`ifdef BRANCH_UPDATE_STATS_EN
   always_ff @(posedge CLK) begin
      if (RST || stat_clr) begin
         stat_branches <= '0;
         stat_mispred  <= '0;
      end else begin
         if (push && stat_branches != '1) stat_branches <= stat_branches + 32'd1;
         if (push && mispredict && stat_mispred != '1) stat_mispred <= stat_mispred + 32'd1;
      end
   end
`endif
endmodule

// File: tb/tb_branch_update_unit.sv
// Randomized bench for branch_update_unit against a queue-based reference model.
module tb_branch_update_unit;
   localparam logic [1:0] NS = 2'd0;
   localparam logic [1:0] NH = 2'd1;
   localparam logic [1:0] TS = 2'd2;
   localparam logic [1:0] TH = 2'd3;
   localparam int DEPTH = 4;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   branch_update_unit_if bu();

`ifdef BRANCH_UPDATE_STATS_EN
   logic [31:0] stat_branches, stat_mispred;
   logic        stat_clr = 1'b0;
   logic [31:0] e_br = 0, e_mp = 0;
`endif

   branch_update_unit #(.DEPTH(DEPTH), .IDX_W(8)) dut (
      .CLK(CLK),
      .RST(RST),
      .bu(bu)
`ifdef BRANCH_UPDATE_STATS_EN
      ,
      .stat_branches(stat_branches),
      .stat_mispred(stat_mispred),
      .stat_clr(stat_clr)
`endif
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [31:0] pc;
      logic [1:0]  st;
      logic [31:0] tgt;
      logic        phit;
   } ent_t;

   ent_t        q[$];
   logic        e_flush = 1'b0;
   logic [31:0] e_fpc = '0;
   bit          mvalid = 0;
   int          checks = 0;
   int          errors = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock: drive at edge+1, check model vs DUT, advance model across the edge.
   task automatic cyc(input logic v, input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                      input logic [1:0] st, input logic [31:0] pt, input logic stall, input logic r);
      bit acc, ptk, dmiss, mis;
      ent_t e;
      bu.res_valid = v; bu.res_pc = pc; bu.res_taken = tk; bu.res_target = tgt;
      bu.res_pred_state = st; bu.res_pred_target = pt; bu.btb_stall = stall; RST = r;
      #1;
      if (mvalid) begin
         chk("ready", bu.res_ready, q.size() < DEPTH);
         chk("flush", bu.flush, e_flush);
         chk("flush_pc", bu.flush_pc, e_fpc);
         chk("wen", bu.btb_wen, q.size() != 0);
         chk("wsel", bu.btb_wsel, q.size() != 0 ? q[0].pc : 32'd0);
         chk("wstate", bu.btb_wstate, q.size() != 0 ? q[0].st : 2'd0);
         chk("wtarget", bu.btb_wtarget, q.size() != 0 ? q[0].tgt : 32'd0);
         chk("phit", bu.btb_phit, q.size() != 0 ? q[0].phit : 1'b0);
`ifdef BRANCH_UPDATE_STATS_EN
         chk("stat_br", stat_branches, e_br);
         chk("stat_mp", stat_mispred, e_mp);
`endif
      end
      acc   = v && (q.size() < DEPTH);
      ptk   = (st == TS) || (st == TH);
      dmiss = ptk != tk;
      mis   = dmiss || (tk && ptk && pt != tgt);
      e.pc = pc; e.st = st; e.tgt = tk ? tgt : pt; e.phit = !dmiss;
      @(posedge CLK);
      #1;
      if (r) begin
         q.delete();
         e_flush = 0; e_fpc = 0; mvalid = 1;
`ifdef BRANCH_UPDATE_STATS_EN
         e_br = 0; e_mp = 0;
`endif
      end else begin
         if (q.size() != 0 && !stall) q.delete(0);
         if (acc) q.push_back(e);
         e_flush = acc && mis;
         e_fpc   = e_flush ? (tk ? tgt : pc + 32'd4) : 32'd0;
`ifdef BRANCH_UPDATE_STATS_EN
         if (acc && e_br != 32'hFFFFFFFF) e_br++;
         if (acc && mis && e_mp != 32'hFFFFFFFF) e_mp++;
`endif
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, NS, 0, 0, 0);
   endtask

   initial begin
      cyc(0, 0, 0, 0, NS, 0, 0, 1);
      cyc(0, 0, 0, 0, NS, 0, 0, 1);
      chk("rst_wen", bu.btb_wen, 0);
      chk("rst_flush", bu.flush, 0);
      chk("rst_fpc", bu.flush_pc, 0);
      chk("rst_ready", bu.res_ready, 1);
      idle(1);

      // correct not-taken
      cyc(1, 32'h100, 0, 32'h0, NS, 32'h1234, 0, 0);
      chk("nt_flush", bu.flush, 0);
      chk("nt_wen", bu.btb_wen, 1);
      chk("nt_wsel", bu.btb_wsel, 32'h100);
      chk("nt_wstate", bu.btb_wstate, NS);
      chk("nt_phit", bu.btb_phit, 1);
      chk("nt_wtarget", bu.btb_wtarget, 32'h1234);
      idle(2);

      // direction miss
      cyc(1, 32'h200, 1, 32'h400, NS, 32'h999, 0, 0);
      chk("dm_flush", bu.flush, 1);
      chk("dm_fpc", bu.flush_pc, 32'h400);
      chk("dm_wstate", bu.btb_wstate, NS);
      chk("dm_phit", bu.btb_phit, 0);
      chk("dm_wtarget", bu.btb_wtarget, 32'h400);
      idle(1);
      chk("dm_pulse", bu.flush, 0);
      chk("dm_fpc0", bu.flush_pc, 0);
      idle(1);

      // target miss
      cyc(1, 32'h280, 1, 32'h380, TH, 32'h300, 0, 0);
      chk("tm_flush", bu.flush, 1);
      chk("tm_fpc", bu.flush_pc, 32'h380);
      chk("tm_phit", bu.btb_phit, 1);
      chk("tm_wtarget", bu.btb_wtarget, 32'h380);
      idle(2);

      // fill under stall, then drain in order
      for (int i = 0; i < 4; i++) cyc(1, 32'h1000 + 32'(i) * 4, 1, 32'h2000, TH, 32'h2000, 1, 0);
      chk("fill_ready", bu.res_ready, 0);
      chk("fill_wsel", bu.btb_wsel, 32'h1000);
      cyc(1, 32'h5000, 0, 0, NS, 0, 1, 0);
      chk("fill_hold", bu.btb_wsel, 32'h1000);
      for (int i = 0; i < 4; i++) begin
         chk("drain_wsel", bu.btb_wsel, 32'h1000 + 32'(i) * 4);
         idle(1);
      end
      chk("drain_done", bu.btb_wen, 0);

      // not-taken mispredict wrapping at top of address space
      cyc(1, 32'hFFFFFFFC, 0, 32'h40, TS, 32'h40, 0, 0);
      chk("wrap_flush", bu.flush, 1);
      chk("wrap_fpc", bu.flush_pc, 32'h0);
      idle(2);

      // back-to-back mispredicts
      cyc(1, 32'h600, 1, 32'h700, NH, 0, 0, 0);
      cyc(1, 32'h604, 0, 0, TS, 32'h800, 0, 0);
      chk("b2b_flush", bu.flush, 1);
      chk("b2b_fpc", bu.flush_pc, 32'h608);
      idle(3);

      // reset with queued entries and a pending flush
      cyc(1, 32'h900, 0, 0, NS, 0, 1, 0);
      cyc(1, 32'h904, 0, 0, NS, 0, 1, 0);
      cyc(1, 32'h908, 1, 32'hA00, NS, 0, 1, 0);
      chk("mr_pend", bu.flush, 1);
      cyc(1, 32'h90C, 1, 32'hB00, NS, 0, 1, 1);
      chk("mr_wen", bu.btb_wen, 0);
      chk("mr_flush", bu.flush, 0);
      chk("mr_ready", bu.res_ready, 1);
      for (int i = 0; i < 3; i++) begin
         idle(1);
         chk("mr_nowrite", bu.btb_wen, 0);
      end

      // randomized traffic
      for (int n = 0; n < 600; n++) begin
         logic [31:0] pc, tgt, pt;
         logic [1:0]  st;
         pc  = {$urandom_range(0, 32'h3FFFFFFF), 2'b00};
         tgt = {$urandom_range(0, 32'h3FFFFFFF), 2'b00};
         pt  = ($urandom_range(0, 1) != 0) ? tgt : {$urandom_range(0, 32'h3FFFFFFF), 2'b00};
         st  = 2'($urandom_range(0, 3));
`ifdef BRANCH_UPDATE_STATS_EN
         stat_clr = ($urandom_range(0, 99) == 0);
         if (stat_clr) begin
            cyc($urandom_range(0, 9) < 7, pc, 1'($urandom_range(0, 1)), tgt, st, pt,
                $urandom_range(0, 9) < 3, 0);
            e_br = 0; e_mp = 0;
            stat_clr = 0;
            continue;
         end
`endif
         cyc($urandom_range(0, 9) < 7, pc, 1'($urandom_range(0, 1)), tgt, st, pt,
             $urandom_range(0, 9) < 3, $urandom_range(0, 99) == 0);
      end
      idle(8);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
